// File: rtl/board_input_ctrl_if.sv
// CPU-facing side of the board input controller: conditioned button levels, step pulse,
// and the switch-operand valid/ack handshake.
interface board_input_ctrl_if #(
  parameter int N = 8
);
  logic [3:0]   buttonLevel;
  logic         cpuResetReq;
  logic         stepPulse;
  logic [N-1:0] switchData;
  logic         switchValid;
  logic         switchAck;
  logic         overrun;

  modport master (
    output buttonLevel, cpuResetReq, stepPulse, switchData, switchValid, overrun,
    input  switchAck
  );

  modport slave (
    input  buttonLevel, cpuResetReq, stepPulse, switchData, switchValid, overrun,
    output switchAck
  );
endinterface

// File: rtl/board_input_ctrl.sv
// Board input conditioning for picoMIPS: synchronise and debounce buttons/switches,
// generate a single-cycle step pulse and hand a captured switch operand to the CPU.
module board_input_ctrl #(
  parameter int N               = 8,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          buttonIn,
  input  logic [SW_WIDTH-1:0] switchIn,
  board_input_ctrl_if.master  cpu
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]          btn_sync_p0, btn_sync_p1;
  logic [SW_WIDTH-1:0] sw_sync_p0, sw_sync_p1;
  logic [3:0]          btn_smp;
  logic [3:0]          btn_stable;
  logic [CW-1:0]       btn_cnt [4];
  logic [SW_WIDTH-1:0] sw_stable;
  logic [CW-1:0]       sw_cnt;
  logic [2:1]          btn_prev;
  logic                step_pulse;
  logic [N-1:0]        sw_data;
  logic                sw_valid;
  logic                sw_overrun;
  logic                cap_req;
  logic                cap_accept;
  logic                unused_sw;

  // Stage p0/p1: two-flop synchronisers; buttons idle high (released)
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_p0 <= 4'hF;
      btn_sync_p1 <= 4'hF;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_sync_p0 <= buttonIn;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= switchIn;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  assign btn_smp = ~btn_sync_p1;

  // Debounce: each button has its own counter, the switch vector shares one
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_stable <= '0;
      sw_stable  <= '0;
      sw_cnt     <= '0;
      for (int i = 0; i < 4; i++) btn_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_smp[i] == btn_stable[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == CNT_MAX) begin
          btn_stable[i] <= btn_smp[i];
          btn_cnt[i]    <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + 1'b1;
        end
      end
      if (sw_sync_p1 == sw_stable) begin
        sw_cnt <= '0;
      end else if (sw_cnt == CNT_MAX) begin
        sw_stable <= sw_sync_p1;
        sw_cnt    <= '0;
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end
    end
  end

  assign cap_req    = btn_stable[2] & ~btn_prev[2];
  assign cap_accept = cap_req & (~sw_valid | cpu.switchAck);

  // Stage p2: registered press-edge detect, step pulse and capture handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev   <= '0;
      step_pulse <= 1'b0;
      sw_data    <= '0;
      sw_valid   <= 1'b0;
      sw_overrun <= 1'b0;
    end else begin
      btn_prev   <= btn_stable[2:1];
      step_pulse <= btn_stable[1] & ~btn_prev[1];
      if (cap_accept) begin
        sw_data  <= sw_stable[N-1:0];
        sw_valid <= 1'b1;
      end else if (cap_req) begin
        sw_overrun <= 1'b1;
      end else if (cpu.switchAck) begin
        sw_valid <= 1'b0;
      end
    end
  end

  // Switches above the operand width are debounced but not delivered
  assign unused_sw = ^sw_stable;

  assign cpu.buttonLevel = btn_stable;
  assign cpu.cpuResetReq = btn_stable[0];
  assign cpu.stepPulse   = step_pulse;
  assign cpu.switchData  = sw_data;
  assign cpu.switchValid = sw_valid;
  assign cpu.overrun     = sw_overrun;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Bench for board_input_ctrl: directed scenarios plus random button/switch/ack traffic,
// checked every cycle against a sliding-window behavioural model.
module tb_board_input_ctrl;

  localparam int D  = 4;
  localparam int N  = 8;
  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    btn_in;
  logic [SW-1:0] sw_in;
  logic          ack;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses;

  board_input_ctrl_if #(.N(N)) bus ();
  assign bus.switchAck = ack;

  board_input_ctrl #(
    .N(N),
    .SW_WIDTH(SW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buttonIn(btn_in),
    .switchIn(sw_in),
    .cpu(bus)
  );

  always #5 clk = ~clk;

  // Reference model state: synchroniser delay line, last D samples, accepted levels
  logic [3:0]    m_bs0, m_bs1;
  logic [SW-1:0] m_ss0, m_ss1;
  logic [3:0]    m_bwin [D];
  logic [SW-1:0] m_swin [D];
  logic [3:0]    m_lvl, m_lvl_prev;
  logic [SW-1:0] m_sw;
  logic          m_step, m_valid, m_ovr;
  logic [N-1:0]  m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // A level is accepted once the last D synchronised samples all disagree with it
  task automatic model_edge();
    logic cap;
    logic all_diff;
    if (rst) begin
      m_bs0 = 4'hF; m_bs1 = 4'hF; m_ss0 = '0; m_ss1 = '0;
      for (int j = 0; j < D; j++) begin m_bwin[j] = '0; m_swin[j] = '0; end
      m_lvl = '0; m_lvl_prev = '0; m_sw = '0;
      m_step = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    end else begin
      cap    = m_lvl[2] & ~m_lvl_prev[2];
      m_step = m_lvl[1] & ~m_lvl_prev[1];
      if (cap) begin
        if (!m_valid || ack) begin m_data = m_sw[N-1:0]; m_valid = 1'b1; end
        else m_ovr = 1'b1;
      end else if (ack) begin
        m_valid = 1'b0;
      end
      m_lvl_prev = m_lvl;
      for (int j = D - 1; j > 0; j--) begin m_bwin[j] = m_bwin[j-1]; m_swin[j] = m_swin[j-1]; end
      m_bwin[0] = ~m_bs1;
      m_swin[0] = m_ss1;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (m_bwin[j][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[i] = m_bwin[0][i];
          for (int j = 0; j < D; j++) m_bwin[j][i] = m_lvl[i];
        end
      end
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (m_swin[j] == m_sw) all_diff = 1'b0;
      if (all_diff) begin
        m_sw = m_swin[0];
        for (int j = 0; j < D; j++) m_swin[j] = m_sw;
      end
      m_bs1 = m_bs0; m_bs0 = btn_in;
      m_ss1 = m_ss0; m_ss0 = sw_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("buttonLevel", 32'(bus.buttonLevel), 32'(m_lvl));
    check("cpuResetReq", 32'(bus.cpuResetReq), 32'(m_lvl[0]));
    check("stepPulse",   32'(bus.stepPulse),   32'(m_step));
    check("switchData",  32'(bus.switchData),  32'(m_data));
    check("switchValid", 32'(bus.switchValid), 32'(m_valid));
    check("overrun",     32'(bus.overrun),     32'(m_ovr));
    if (bus.stepPulse) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, bus.buttonLevel, bus.cpuResetReq, bus.stepPulse,
            bus.switchData, bus.switchValid, bus.overrun};
  endfunction

  initial begin
    rst = 1'b1; btn_in = 4'hF; sw_in = '0; ack = 1'b0; pulses = 0;

    // Reset, then idle
    ticks(2);
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    ticks(20);
    check("idle_outs", all_outs(), 32'd0);

    // Clean step press: level at edge 6, pulse at edge 7 only
    btn_in[1] = 1'b0;
    ticks(5);
    check("step_lvl_e5", 32'(bus.buttonLevel[1]), 32'd0);
    tick();
    check("step_lvl_e6", 32'(bus.buttonLevel[1]), 32'd1);
    check("step_nopulse_e6", 32'(bus.stepPulse), 32'd0);
    tick();
    check("step_pulse_e7", 32'(bus.stepPulse), 32'd1);
    pulses = 0;
    ticks(13);
    check("step_hold_pulses", 32'(pulses), 32'd0);
    btn_in[1] = 1'b1;
    pulses = 0;
    ticks(12);
    check("release_pulses", 32'(pulses), 32'd0);
    check("release_lvl", 32'(bus.buttonLevel[1]), 32'd0);

    // Bouncing press
    btn_in[1] = 1'b0; tick();
    btn_in[1] = 1'b1; tick();
    btn_in[1] = 1'b0; tick();
    btn_in[1] = 1'b1; tick();
    btn_in[1] = 1'b0;
    pulses = 0;
    ticks(6);
    check("bounce_early_pulses", 32'(pulses), 32'd0);
    tick();
    check("bounce_pulse_e7", 32'(bus.stepPulse), 32'd1);
    ticks(10);
    check("bounce_total_pulses", 32'(pulses), 32'd1);
    btn_in[1] = 1'b1;
    ticks(12);

    // Capture then ack
    sw_in = 10'h2A5;
    ticks(10);
    btn_in[2] = 1'b0;
    ticks(7);
    check("cap_data", 32'(bus.switchData), 32'h0A5);
    check("cap_valid", 32'(bus.switchValid), 32'd1);
    btn_in[2] = 1'b1;
    ack = 1'b1; tick(); ack = 1'b0;
    check("ack_valid", 32'(bus.switchValid), 32'd0);
    check("ack_data", 32'(bus.switchData), 32'h0A5);
    ticks(10);

    // Overrun, then capture aligned with ack
    sw_in = 10'h011; ticks(8);
    btn_in[2] = 1'b0; ticks(7);
    check("ovr_first_data", 32'(bus.switchData), 32'h011);
    btn_in[2] = 1'b1; ticks(8);
    sw_in = 10'h022; ticks(8);
    btn_in[2] = 1'b0; ticks(7);
    check("ovr_kept_data", 32'(bus.switchData), 32'h011);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    btn_in[2] = 1'b1; ticks(8);
    btn_in[2] = 1'b0; ticks(6);
    ack = 1'b1; tick(); ack = 1'b0;
    check("same_cycle_data", 32'(bus.switchData), 32'h022);
    check("same_cycle_valid", 32'(bus.switchValid), 32'd1);
    btn_in[2] = 1'b1; ticks(8);

    // Reset mid-debounce of a held BUTTON[0]
    btn_in[0] = 1'b0;
    ticks(4);
    rst = 1'b1;
    tick();
    check("midrst_outs", all_outs(), 32'd0);
    tick();
    rst = 1'b0;
    ticks(5);
    check("midrst_e5", 32'(bus.cpuResetReq), 32'd0);
    tick();
    check("midrst_e6", 32'(bus.cpuResetReq), 32'd1);
    btn_in[0] = 1'b1;
    ticks(10);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) begin
        int b;
        b = int'($urandom_range(3));
        btn_in[b] = ~btn_in[b];
      end
      if ($urandom_range(15) == 0) sw_in = SW'($urandom);
      ack = ($urandom_range(3) == 0);
      rst = ($urandom_range(300) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
